// File: rtl/input_conditioner_pkg.sv
// Shared constants, longpress state encoding and width helpers for the
// board input conditioner.
package input_cond_pkg;

    localparam int DEF_N_BTN            = 4;
    localparam int DEF_N_SW             = 4;
    localparam int DEF_DEBOUNCE_CYCLES  = 500000;
    localparam int DEF_LONGPRESS_CYCLES = 150000000;
    localparam int DEF_RST_PULSE_CYCLES = 64;

    typedef logic [1:0] lp_state_t;
    localparam lp_state_t LP_IDLE     = 2'd0;
    localparam lp_state_t LP_COUNT    = 2'd1;
    localparam lp_state_t LP_FIRE     = 2'd2;
    localparam lp_state_t LP_WAIT_REL = 2'd3;

    typedef struct packed {
        logic level;   // debounced (accepted) value
        logic sample;  // synchronised pin value
        logic accept;  // sample is taken into level on this edge
    } deb_out_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce.sv
// One-bit two-flop synchroniser plus debouncer; a new value is taken only
// after it has been seen for DEBOUNCE_CYCLES consecutive samples.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     din,
    output deb_out_t dout
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, q;
    logic [CW-1:0] cnt;
    logic          differ, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign differ = (sync2 != q);
    assign accept = differ && (cnt == CNT_LAST);

    // Any return to the stable value restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= RESET_VAL;
            cnt <= '0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (accept) begin
            q   <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dout = '{level: q, sample: sync2, accept: accept};

endmodule

// File: rtl/input_conditioner.sv
// Conditions KEY/SW pins for the PIOs: debounce, edge pulses, and a
// long-press detector that issues a timed HPS warm-reset request.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_BTN            = DEF_N_BTN,
    parameter int N_SW             = DEF_N_SW,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
    parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
    parameter int LONGPRESS_BTN    = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] key_n_in,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_BTN-1:0] btn_pio_out,
    output logic [N_BTN-1:0] btn_press_pulse,
    output logic [N_SW-1:0]  sw_pio_out,
    output logic [N_SW-1:0]  sw_change_pulse,
    output logic             warm_rst_req_n
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int            LW       = cnt_width(max_int(LONGPRESS_CYCLES, RST_PULSE_CYCLES));
    localparam logic [LW-1:0] LP_LAST  = LW'(LONGPRESS_CYCLES - 1);
    localparam logic [LW-1:0] RP_LAST  = LW'(RST_PULSE_CYCLES - 1);

    logic [N_BTN-1:0] btn_acc, btn_smp;
    logic [N_SW-1:0]  sw_acc, sw_primed;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        deb_out_t d;
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b1)
        ) u_deb (
            .clk  (clk_clk),
            .rst_n(reset_reset_n),
            .din  (key_n_in[i]),
            .dout (d)
        );
        assign btn_pio_out[i] = d.level;
        assign btn_acc[i]     = d.accept;
        assign btn_smp[i]     = d.sample;
    end

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        deb_out_t      d;
        logic          primed;
        logic [CW-1:0] pcnt;
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b0)
        ) u_deb (
            .clk  (clk_clk),
            .rst_n(reset_reset_n),
            .din  (sw_in[j]),
            .dout (d)
        );
        // Primed once the switch has either been accepted or sat settled for
        // a full debounce window; until then changes raise no pulse.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                primed <= 1'b0;
                pcnt   <= '0;
            end else if (!primed) begin
                if (d.accept)
                    primed <= 1'b1;
                else if (d.sample != d.level)
                    pcnt <= '0;
                else if (pcnt == DEB_LAST)
                    primed <= 1'b1;
                else
                    pcnt <= pcnt + 1'b1;
            end
        end
        assign sw_pio_out[j] = d.level;
        assign sw_acc[j]     = d.accept;
        assign sw_primed[j]  = primed;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_press_pulse <= '0;
            sw_change_pulse <= '0;
        end else begin
            btn_press_pulse <= btn_acc & ~btn_smp;
            sw_change_pulse <= sw_acc & sw_primed;
        end
    end

    lp_state_t     state, state_d;
    logic [LW-1:0] lp_cnt, lp_cnt_d;
    logic          warm_d;
    logic          lp_pressed;

    assign lp_pressed = ~btn_pio_out[LONGPRESS_BTN];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= LP_IDLE;
            lp_cnt         <= '0;
            warm_rst_req_n <= 1'b1;
        end else begin
            state          <= state_d;
            lp_cnt         <= lp_cnt_d;
            warm_rst_req_n <= warm_d;
        end
    end

    // lp_cnt times the hold in COUNT and the pulse width in FIRE.
    always_comb begin
        state_d  = state;
        lp_cnt_d = lp_cnt;
        case (state)
            LP_IDLE: begin
                if (lp_pressed) begin
                    state_d  = LP_COUNT;
                    lp_cnt_d = '0;
                end
            end
            LP_COUNT: begin
                if (!lp_pressed) begin
                    state_d = LP_IDLE;
                end else if (lp_cnt == LP_LAST) begin
                    state_d  = LP_FIRE;
                    lp_cnt_d = '0;
                end else begin
                    lp_cnt_d = lp_cnt + 1'b1;
                end
            end
            LP_FIRE: begin
                if (lp_cnt == RP_LAST)
                    state_d = LP_WAIT_REL;
                else
                    lp_cnt_d = lp_cnt + 1'b1;
            end
            LP_WAIT_REL: begin
                if (!lp_pressed)
                    state_d = LP_IDLE;
            end
            default: state_d = LP_IDLE;
        endcase
    end

    always_comb begin
        warm_d = (state_d != LP_FIRE);
    end

endmodule
